reg_slice_vld_rdy: RTL and testbench
====================================

// Module: reg_slice_vld_rdy
// PURPOSE
//   Two-entry valid/ready pipeline register slice (skid buffer) for the reg_* family.
//   Cuts the forward data/valid path and the backward ready path between two stages.
//   Sits directly upstream of plain data registers; o_data/o_valid feed them.
//   Full throughput: one beat per cycle, with no bubble under sustained backpressure release.
// PARAMETERS
//   DATA_WIDTH  32  width of the payload in bits
// PORTS
//   i_clk    in   1           single clock, rising edge
//   i_rst_n  in   1           reset, asynchronous assert, active-low
//   i_flush  in   1           synchronous drop of all held beats
//   i_valid  in   1           upstream beat valid
//   o_ready  out  1           slice can accept a beat (registered)
//   i_data   in   DATA_WIDTH  upstream payload
//   o_valid  out  1           downstream beat valid (registered)
//   i_ready  in   1           downstream accepts beat
//   o_data   out  DATA_WIDTH  downstream payload (main register)
//   o_level  out  2           beats held: 0, 1 or 2
// BEHAVIOUR
//   Clocking/reset: one clock; reset is asynchronous and active-low on i_rst_n.
//   Reset state: ST_EMPTY; o_valid=0, o_ready=1, o_level=0.
//   Data registers: main and skid are not reset. Writes use the `REG_DELAY_CYCLE delay.
//   o_data is don't-care while o_valid=0.
//   Handshake events: in_fire = i_valid & o_ready; out_fire = o_valid & i_ready.
//   Protocol: o_valid/o_data stay stable until out_fire. o_ready never depends combinationally on i_ready.
//   Output decode: o_valid = (state != ST_EMPTY); o_ready = (state != ST_FULL).
//   o_level decode: EMPTY=0, BUSY=1, FULL=2.
//   Transitions (priority: flush > fires):
//     any state, i_flush=1      -> ST_EMPTY; data registers untouched; a coincident in_fire is dropped.
//     ST_EMPTY, in_fire         -> ST_BUSY; main <= i_data.
//     ST_BUSY, in & out fire    -> ST_BUSY; main <= i_data.
//     ST_BUSY, in_fire only     -> ST_FULL; skid <= i_data; main holds.
//     ST_BUSY, out_fire only    -> ST_EMPTY.
//     ST_FULL, out_fire         -> ST_BUSY; main <= skid. in_fire is impossible (o_ready=0).
//     ST_FULL, no out_fire      -> hold.
//   Latency: in_fire at cycle N -> o_valid=1 with that data at N+1 when the slice was empty.
//   Ordering: strictly FIFO; no beat duplicated or lost except by flush/reset.
//   Reset mid-transfer: all held beats are discarded immediately; o_valid drops asynchronously.
//   Illegal state encoding: recovers to ST_EMPTY on the next edge.
// STRUCTURE
//   reg_pkg holds:
//     typedef enum logic [1:0] {ST_EMPTY=2'b00, ST_BUSY=2'b01, ST_FULL=2'b10} slice_state_e;
//     localparam SLICE_DEPTH = 2.
//   Sub-module: reg_chk on i_data, enabled under `REG_CHECK. It is the only instance.
//   Everything else is one always_ff for state, one always_ff for data, and combinational decode.
// TESTING
//   1 Reset: i_rst_n=0 mid-stream with 2 beats held -> o_valid=0, o_ready=1, o_level=0.
//     The beats never appear after release.
//   2 Streaming: i_ready=1, push 0x1..0x8 back-to-back.
//     -> o_data 0x1..0x8 on consecutive cycles, 1-cycle latency, o_level stays 1.
//   3 Backpressure: i_ready=0, push 0xA,0xB,0xC.
//     -> 0xA and 0xB accepted, o_ready=0 after 0xB, o_level=2, 0xC held by upstream.
//     Release i_ready -> 0xA,0xB,0xC out in order with no gap.
//   4 Flush: hold 0x11,0x22 (FULL), assert i_flush with i_valid=1, data 0x33.
//     -> next cycle o_valid=0, o_level=0; 0x33 not delivered.
//   5 Random: random i_valid/i_ready, 10k beats of incrementing data.
//     -> scoreboard exact in-order match; o_data stable while o_valid & !i_ready.
//     o_ready never combinationally follows i_ready.

Source files
------------

// File: rtl/reg_pkg.sv
// reg_pkg: shared types and constants for the reg_* slice family.
// Holds the slice state encoding and the depth-to-level helper.
`ifndef REG_DELAY_CYCLE
`define REG_DELAY_CYCLE
`endif

package reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b10
    } slice_state_e;

    localparam int unsigned SLICE_DEPTH = 2;

    // Number of beats held in a given state; illegal codes hold none.
    function automatic logic [1:0] state_level(input slice_state_e st);
        logic [1:0] lvl;
        lvl = 2'd0;
        unique case (st)
            ST_BUSY: lvl = 2'd1;
            ST_FULL: lvl = 2'(SLICE_DEPTH);
            default: lvl = 2'd0;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/reg_chk.sv
// reg_chk: payload sanity checker for the upstream side of a slice.
// Flags an unknown payload presented with a valid beat when enabled.
import reg_pkg::*;

module reg_chk #(
    parameter int DATA_WIDTH = 32,
    parameter bit EN         = 1'b0
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    input logic                  i_valid,
    input logic [DATA_WIDTH-1:0] i_data
);

    // A valid beat must carry a fully known payload.
    a_data_known: assert property (
        @(posedge i_clk) disable iff (!i_rst_n || !EN)
        i_valid |-> !$isunknown(i_data)
    );

endmodule

// File: rtl/reg_slice_vld_rdy.sv
// reg_slice_vld_rdy: two-entry valid/ready skid slice.
// Registers valid, ready and data so neither direction has a comb path.
`ifndef REG_DELAY_CYCLE
`define REG_DELAY_CYCLE
`endif

import reg_pkg::*;

module reg_slice_vld_rdy #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_level
);

`ifdef REG_CHECK
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    slice_state_e          state_q;
    slice_state_e          state_d;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  in_fire;
    logic                  out_fire;
    logic                  load_main;
    logic                  load_skid;
    logic                  skid_to_main;

    assign o_valid  = (state_q != ST_EMPTY);
    assign o_ready  = (state_q != ST_FULL);
    assign o_level  = state_level(state_q);
    assign o_data   = main_q;
    assign in_fire  = i_valid & o_ready;
    assign out_fire = o_valid & i_ready;

    // State register; reset empties the slice immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and data-register load selects; flush wins over fires.
    always_comb begin
        state_d      = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (i_flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d   = ST_BUSY;
                        load_main = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (in_fire && out_fire) begin
                        load_main = 1'b1;
                    end else if (in_fire) begin
                        state_d   = ST_FULL;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d      = ST_BUSY;
                        skid_to_main = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Payload registers; no reset since o_valid qualifies them.
    always_ff @(posedge i_clk) begin
        if (load_main) begin
            main_q <= `REG_DELAY_CYCLE i_data;
        end else if (skid_to_main) begin
            main_q <= `REG_DELAY_CYCLE skid_q;
        end
        if (load_skid) begin
            skid_q <= `REG_DELAY_CYCLE i_data;
        end
    end

    reg_chk #(
        .DATA_WIDTH (DATA_WIDTH),
        .EN         (CHK_EN)
    ) u_chk (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .i_data  (i_data)
    );

endmodule

// File: tb/tb_reg_slice_vld_rdy.sv
// tb_reg_slice_vld_rdy: directed and random checks of the skid slice.
// Expected values are hand-derived or come from a beat queue.
`timescale 1ns/1ps

module tb_reg_slice_vld_rdy;

    localparam int DW = 32;
    localparam int N_BEATS = 10000;
    localparam int MAX_CYC = 60000;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_flush;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
    logic [1:0]    o_level;

    int vectors = 0;
    int miscompares = 0;

    reg_slice_vld_rdy #(.DATA_WIDTH(DW)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_flush),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_level (o_level)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_st(input string tag, input logic v, input logic r,
                          input logic [1:0] l);
        check({tag, ".valid"}, 32'(o_valid), 32'(v));
        check({tag, ".ready"}, 32'(o_ready), 32'(r));
        check({tag, ".level"}, 32'(o_level), 32'(l));
    endtask

    logic [DW-1:0] q[$];
    logic [DW-1:0] next_data;
    logic [DW-1:0] exp_d;
    logic [DW-1:0] prev_data;
    logic          prev_hold;
    logic          in_f;
    logic          out_f;
    logic          r0;
    logic          vld;
    logic          rdy;
    int            cyc;

    initial begin
        i_rst_n = 1'b0;
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
        #12;
        chk_st("rst", 1'b0, 1'b1, 2'd0);
        i_rst_n = 1'b1;
        tick();
        chk_st("idle", 1'b0, 1'b1, 2'd0);

        // Streaming: one beat per cycle, 1-cycle latency.
        i_ready = 1'b1;
        i_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            i_data = DW'(k);
            tick();
            check($sformatf("strm%0d.data", k), o_data, 32'(k));
            chk_st($sformatf("strm%0d", k), 1'b1, 1'b1, 2'd1);
        end
        i_valid = 1'b0;
        tick();
        chk_st("strm.drain", 1'b0, 1'b1, 2'd0);

        // Backpressure: A,B fill the slice, C waits upstream.
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'hA;
        tick();
        check("bp.a", o_data, 32'hA);
        chk_st("bp.a", 1'b1, 1'b1, 2'd1);
        i_data = 32'hB;
        tick();
        check("bp.b", o_data, 32'hA);
        chk_st("bp.b", 1'b1, 1'b0, 2'd2);
        i_data = 32'hC;
        tick();
        check("bp.c", o_data, 32'hA);
        chk_st("bp.c", 1'b1, 1'b0, 2'd2);
        i_ready = 1'b1;
        tick();
        check("bp.outb", o_data, 32'hB);
        chk_st("bp.outb", 1'b1, 1'b1, 2'd1);
        tick();
        check("bp.outc", o_data, 32'hC);
        chk_st("bp.outc", 1'b1, 1'b1, 2'd1);
        i_valid = 1'b0;
        tick();
        chk_st("bp.drain", 1'b0, 1'b1, 2'd0);

        // Flush while full with a beat offered; nothing survives.
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'h11;
        tick();
        i_data = 32'h22;
        tick();
        chk_st("fl.full", 1'b1, 1'b0, 2'd2);
        i_flush = 1'b1;
        i_data  = 32'h33;
        tick();
        chk_st("fl.full.flush", 1'b0, 1'b1, 2'd0);
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        chk_st("fl.after", 1'b0, 1'b1, 2'd0);

        // Flush from busy drops a coincident accepted beat.
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'h44;
        tick();
        chk_st("fl.busy", 1'b1, 1'b1, 2'd1);
        i_flush = 1'b1;
        i_data  = 32'h55;
        tick();
        chk_st("fl.busy.flush", 1'b0, 1'b1, 2'd0);
        i_flush = 1'b0;
        i_valid = 1'b0;
        tick();
        chk_st("fl.busy.after", 1'b0, 1'b1, 2'd0);

        // Reset mid-stream with two beats held.
        i_valid = 1'b1;
        i_data  = 32'h66;
        tick();
        i_data = 32'h77;
        tick();
        chk_st("mrst.full", 1'b1, 1'b0, 2'd2);
        i_valid = 1'b0;
        i_rst_n = 1'b0;
        #1;
        chk_st("mrst.async", 1'b0, 1'b1, 2'd0);
        tick();
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        tick();
        tick();
        chk_st("mrst.after", 1'b0, 1'b1, 2'd0);

        // Random traffic against an in-order beat queue.
        next_data = 32'h1000;
        vld = 1'b0;
        in_f = 1'b0;
        prev_hold = 1'b0;
        prev_data = '0;
        cyc = 0;
        while ((next_data != 32'h1000 + N_BEATS || q.size() != 0)
               && cyc < MAX_CYC) begin
            cyc++;
            if (!(vld && !in_f)) begin
                vld = (next_data != 32'h1000 + N_BEATS) &&
                      ($urandom_range(0, 3) != 0);
            end
            rdy = ($urandom_range(0, 2) != 0);
            i_valid = vld;
            i_data  = next_data;
            i_ready = ~rdy;
            #1;
            r0 = o_ready;
            i_ready = rdy;
            #1;
            check("rnd.ready_indep", 32'(o_ready), 32'(r0));
            in_f  = i_valid & o_ready;
            out_f = o_valid & i_ready;
            if (out_f) begin
                exp_d = (q.size() != 0) ? q.pop_front() : 32'hDEAD_BEEF;
                check("rnd.data", o_data, exp_d);
            end
            prev_hold = o_valid & ~i_ready;
            prev_data = o_data;
            if (in_f) begin
                q.push_back(next_data);
                next_data = next_data + 1;
            end
            tick();
            check("rnd.level", 32'(o_level), 32'(q.size()));
            if (prev_hold) begin
                check("rnd.stable", o_data, prev_data);
            end
        end
        i_valid = 1'b0;
        check("rnd.budget", 32'(cyc < MAX_CYC), 32'd1);
        check("rnd.count", next_data, 32'h1000 + N_BEATS);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
